// File: rtl/i2s_rx_deser.sv
// i2s_rx_deser: I2S receiver on adc_clk; bclk/wclk/sdata in, stereo pair out with valid/ready, sticky overflow and frame_err
module i2s_rx_deser #(
  parameter int SAMPLE_SIZE = 24,
  parameter int BIT_CNT_W = 5
) (
  input  logic                   adc_clk,
  input  logic                   rst,
  input  logic                   i2s_bclk,
  input  logic                   i2s_wclk,
  input  logic                   i2s_sdata,
  output logic [SAMPLE_SIZE-1:0] out_left,
  output logic [SAMPLE_SIZE-1:0] out_right,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overflow,
  output logic                   frame_err
);
  localparam logic [1:0] SYNC = 2'd0;
  localparam logic [1:0] LEFT = 2'd1;
  localparam logic [1:0] RIGHT = 2'd2;
  localparam logic [BIT_CNT_W:0] LEN = (BIT_CNT_W + 1)'(SAMPLE_SIZE);
  localparam logic [BIT_CNT_W-1:0] CNT_MAX = '1;
  logic                   bclk_q;
  logic                   wclk_prev;
  logic [1:0]             state;
  logic [1:0]             state_nx;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [SAMPLE_SIZE-1:0] shreg;
  logic [SAMPLE_SIZE-1:0] left_stage;
  logic [SAMPLE_SIZE-1:0] word;
  logic                   rise;
  logic                   slot_edge;
  logic                   len_ok;
  logic                   left_done;
  logic                   pair_done;
  logic                   bad;
  assign rise      = i2s_bclk & ~bclk_q;
  assign word      = {shreg[SAMPLE_SIZE-2:0], i2s_sdata};
  assign slot_edge = rise & (i2s_wclk != wclk_prev);
  assign len_ok    = ({1'b0, bit_cnt} + 1'b1) == LEN;
  assign left_done = slot_edge & (state == LEFT) & len_ok;
  assign pair_done = slot_edge & (state == RIGHT) & len_ok;
  assign bad       = slot_edge & (state != SYNC) & ~len_ok;
  assign state_nx  = !slot_edge ? state :
                     (state == LEFT && len_ok) ? RIGHT :
                     (state == RIGHT && len_ok) ? LEFT :
                     i2s_wclk ? SYNC : LEFT;
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      bclk_q     <= 1'b0;
      wclk_prev  <= 1'b0;
      state      <= SYNC;
      bit_cnt    <= '0;
      shreg      <= '0;
      left_stage <= '0;
      out_left   <= '0;
      out_right  <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      bclk_q <= i2s_bclk;
      if (rise) begin
        shreg     <= word;
        wclk_prev <= i2s_wclk;
        bit_cnt   <= slot_edge ? '0 : (bit_cnt == CNT_MAX ? bit_cnt : bit_cnt + 1'b1);
        state     <= state_nx;
      end
      if (left_done) left_stage <= word;
      if (bad) frame_err <= 1'b1;
      if (pair_done && out_valid && !out_ready) overflow <= 1'b1;
      if (pair_done && (!out_valid || out_ready)) begin
        out_left  <= left_stage;
        out_right <= word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2s_rx_deser.sv
// tb_i2s_rx_deser: directed I2S streams against hand-computed stereo pairs and flags
module tb_i2s_rx_deser;
  logic adc_clk = 0, rst = 1, i2s_bclk = 0, i2s_wclk = 0, i2s_sdata = 0, out_ready = 1;
  logic [23:0] out_left, out_right;
  logic out_valid, overflow, frame_err;
  int errors = 0, checks = 0, acc_cnt = 0, rst_pos = -1, a;
  logic [23:0] acc_l = 0, acc_r = 0, f_l, f_r;
  logic pend = 0, f_v1, f_v2, f_ovf;

  always #5 adc_clk = ~adc_clk;

  i2s_rx_deser dut (
    .adc_clk(adc_clk), .rst(rst), .i2s_bclk(i2s_bclk), .i2s_wclk(i2s_wclk),
    .i2s_sdata(i2s_sdata), .out_left(out_left), .out_right(out_right),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow), .frame_err(frame_err)
  );

  always @(negedge adc_clk) if (out_valid && out_ready) begin
    acc_cnt++;
    acc_l = out_left;
    acc_r = out_right;
  end

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task check_zero(input string tag);
    check({tag, "_left"}, 32'(out_left), 0);
    check({tag, "_right"}, 32'(out_right), 0);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
    check({tag, "_ferr"}, 32'(frame_err), 0);
  endtask

  task bit_out(input logic w, input logic d, input logic rp, input logic cap);
    i2s_bclk = 0; i2s_wclk = w; i2s_sdata = d;
    repeat (2) begin @(posedge adc_clk); #1; end
    i2s_bclk = 1;
    if (rp) out_ready = 1;
    @(posedge adc_clk); #1;
    if (rp) out_ready = 0;
    if (cap) begin f_v1 = out_valid; f_l = out_left; f_r = out_right; f_ovf = overflow; end
    @(posedge adc_clk); #1;
    if (cap) f_v2 = out_valid;
  endtask

  task send_slot(input logic w, input logic [23:0] word, input int n, input logic rp);
    for (int j = 0; j < n; j++) begin
      if (j == rst_pos) begin
        rst = 1;
        @(posedge adc_clk); #1;
        check_zero("midrst");
        rst = 0;
      end
      bit_out(w, j == 0 ? pend : word[n-j], j == 0 && rp, j == 0);
    end
    pend = word[0];
  endtask

  initial begin
    repeat (3) @(posedge adc_clk);
    #1;
    check_zero("reset");
    rst = 0;
    a = acc_cnt;
    send_slot(1, 24'h0ABCDE, 10, 0);
    send_slot(0, 24'hA5F00F, 24, 0);
    send_slot(1, 24'h123456, 24, 0);
    check("no_early", 32'(acc_cnt), 32'(a));
    send_slot(0, 24'h000001, 24, 0);
    check("p1_valid", 32'(f_v1), 1);
    check("p1_left", 32'(f_l), 32'hA5F00F);
    check("p1_right", 32'(f_r), 32'h123456);
    check("p1_pulse", 32'(f_v2), 0);
    check("p1_acc", 32'(acc_cnt), 32'(a + 1));
    check("p1_acc_l", 32'(acc_l), 32'hA5F00F);
    check("p1_acc_r", 32'(acc_r), 32'h123456);
    check("p1_ovf", 32'(overflow), 0);
    check("p1_ferr", 32'(frame_err), 0);
    out_ready = 0;
    send_slot(1, 24'h000002, 24, 0);
    send_slot(0, 24'h000003, 24, 0);
    check("hold_valid", 32'(f_v1), 1);
    send_slot(1, 24'h000004, 24, 0);
    rst_pos = 12;
    send_slot(0, 24'h000005, 24, 0);
    rst_pos = -1;
    check("ovf_left", 32'(f_l), 1);
    check("ovf_right", 32'(f_r), 2);
    check("ovf_valid", 32'(f_v2), 1);
    check("ovf_flag", 32'(f_ovf), 1);
    out_ready = 1;
    a = acc_cnt;
    send_slot(1, 24'h000006, 24, 0);
    send_slot(0, 24'h000007, 24, 0);
    send_slot(1, 24'h000008, 24, 0);
    check("rs_no_early", 32'(acc_cnt), 32'(a));
    send_slot(0, 24'h000009, 24, 0);
    check("rs_valid", 32'(f_v1), 1);
    check("rs_left", 32'(f_l), 7);
    check("rs_right", 32'(f_r), 8);
    check("rs_ovf", 32'(f_ovf), 0);
    out_ready = 0;
    send_slot(1, 24'h00000A, 24, 0);
    send_slot(0, 24'h00000B, 24, 0);
    check("same_pend", 32'(f_v1), 1);
    send_slot(1, 24'h00000C, 24, 0);
    a = acc_cnt;
    send_slot(0, 24'h00000D, 24, 1);
    check("same_valid", 32'(f_v1), 1);
    check("same_left", 32'(f_l), 32'hB);
    check("same_right", 32'(f_r), 32'hC);
    check("same_stay", 32'(f_v2), 1);
    check("same_ovf", 32'(f_ovf), 0);
    check("same_acc", 32'(acc_cnt), 32'(a + 1));
    check("same_acc_l", 32'(acc_l), 32'h9);
    check("same_acc_r", 32'(acc_r), 32'hA);
    out_ready = 1;
    send_slot(1, 24'h00000E, 24, 0);
    send_slot(0, 24'h00000F, 23, 0);
    a = acc_cnt;
    send_slot(1, 24'h000010, 24, 0);
    check("short_ferr", 32'(frame_err), 1);
    send_slot(0, 24'h7FFFFF, 24, 0);
    send_slot(1, 24'h800000, 24, 0);
    check("short_dropped", 32'(acc_cnt), 32'(a));
    send_slot(0, 24'h000000, 24, 0);
    check("fe_valid", 32'(f_v1), 1);
    check("fe_left", 32'(f_l), 32'h7FFFFF);
    check("fe_right", 32'(f_r), 32'h800000);
    check("fe_acc", 32'(acc_cnt), 32'(a + 1));
    check("fe_sticky", 32'(frame_err), 1);
    check("fe_ovf", 32'(overflow), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
